// File: rtl/pipe_ctrl.sv
// Pipeline control for the in-order core: hazard/stall/flush generation, halt drain
// sequencing, per-stage valid tracking and saturating stall/flush event counters.
module pipe_ctrl #(
  parameter int STAGES    = 5,
  parameter int EX_STAGE  = 2,
  parameter int MEM_STAGE = 3,
  parameter int ADR_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  id_src1_adr,
  input  logic [ADR_W-1:0]  id_src2_adr,
  input  logic              id_src1_use,
  input  logic              id_src2_use,
  input  logic              halt_id,
  input  logic              ex_load,
  input  logic              ex_regwrite,
  input  logic [ADR_W-1:0]  ex_dst_adr,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              resume,
  output logic              en_pc,
  output logic [STAGES-2:0] en_pipe,
  output logic [STAGES-2:0] flush_pipe,
  output logic [STAGES-1:0] valid,
  output logic              is_halt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int NR = STAGES - 1;
  localparam int DW = $clog2(STAGES);
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(STAGES - 2);
  localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
  localparam logic [DW-1:0]    DRAIN_ZERO = DW'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [NR-1:0]    ALL_ONE    = {NR{1'b1}};
  localparam logic [NR-1:0]    ALL_ZERO   = {NR{1'b0}};

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  state_t            state_r, state_nxt_s;
  logic [DW-1:0]     drain_cnt_r, drain_cnt_nxt_s;
  logic [STAGES-1:1] valid_r;
  logic [STAGES-1:0] valid_all_s;
  logic [NR-1:0]     valid_nxt_s;
  logic              is_halt_r;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              en_pc_s, stall_ev_s, flush_ev_s;
  logic [NR-1:0]     en_pipe_s, flush_pipe_s;
  logic              hazard_s, branch_s, halt_s;

  // Mask with register bits 0..n-1 set.
  function automatic logic [NR-1:0] low_mask(input int n);
    logic [NR-1:0] m;
    for (int k = 0; k < NR; k++) m[k] = (k < n);
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    else    return c + CNT_ONE;
  endfunction

  assign valid_all_s = {valid_r, reset & (state_r == RUN)};
  assign branch_s    = branch_taken & valid_all_s[EX_STAGE];
  assign halt_s      = halt_id & valid_all_s[1];
  assign hazard_s    = ex_load & ex_regwrite & valid_all_s[EX_STAGE] & valid_all_s[1] &
                       ((id_src1_use & (id_src1_adr == ex_dst_adr)) |
                        (id_src2_use & (id_src2_adr == ex_dst_adr)));

  // Next-state, drain counter and raw enable/flush decode.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    en_pc_s         = 1'b1;
    en_pipe_s       = ALL_ONE;
    flush_pipe_s    = ALL_ZERO;
    stall_ev_s      = 1'b0;
    flush_ev_s      = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_busy) begin
          en_pc_s                 = 1'b0;
          en_pipe_s               = ~low_mask(MEM_STAGE);
          flush_pipe_s[MEM_STAGE] = 1'b1;
          stall_ev_s              = 1'b1;
        end else if (branch_s) begin
          flush_pipe_s = low_mask(EX_STAGE);
          flush_ev_s   = 1'b1;
        end else if (hazard_s) begin
          en_pc_s         = 1'b0;
          en_pipe_s[0]    = 1'b0;
          flush_pipe_s[1] = 1'b1;
          stall_ev_s      = 1'b1;
        end else if (halt_s) begin
          state_nxt_s     = DRAIN;
          drain_cnt_nxt_s = DRAIN_LOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        en_pc_s         = 1'b0;
        flush_pipe_s[0] = 1'b1;
        if (mem_busy) begin
          en_pipe_s               = ~low_mask(MEM_STAGE);
          flush_pipe_s[MEM_STAGE] = 1'b1;
        end else if (drain_cnt_r <= DRAIN_ONE) begin
          drain_cnt_nxt_s = DRAIN_ZERO;
          state_nxt_s     = HALTED;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r - DRAIN_ONE;
        end
      end
      HALTED: begin
        en_pc_s   = 1'b0;
        en_pipe_s = ALL_ZERO;
        if (resume) state_nxt_s = RUN;
        else        state_nxt_s = HALTED;
      end
      default: begin
        en_pc_s     = 1'b0;
        en_pipe_s   = ALL_ZERO;
        state_nxt_s = RUN;
      end
    endcase
  end

  // Per-register valid propagation; flush beats enable.
  always_comb begin
    valid_nxt_s = valid_r;
    for (int k = 0; k < NR; k++) begin
      if (flush_pipe_s[k])  valid_nxt_s[k] = 1'b0;
      else if (en_pipe_s[k]) valid_nxt_s[k] = valid_all_s[k];
      else                   valid_nxt_s[k] = valid_r[k+1];
    end
  end

  // State, valid, halt flag and event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= RUN;
      drain_cnt_r <= DRAIN_ZERO;
      valid_r     <= ALL_ZERO;
      is_halt_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      valid_r     <= valid_nxt_s;
      is_halt_r   <= (state_nxt_s == HALTED);
      if (stall_ev_s) stall_cnt_r <= sat_inc(stall_cnt_r);
      else            stall_cnt_r <= stall_cnt_r;
      if (flush_ev_s) flush_cnt_r <= sat_inc(flush_cnt_r);
      else            flush_cnt_r <= flush_cnt_r;
    end
  end

  assign en_pc      = reset & en_pc_s;
  assign en_pipe    = reset ? en_pipe_s : ALL_ZERO;
  assign flush_pipe = reset ? flush_pipe_s : ALL_ONE;
  assign valid      = valid_all_s;
  assign is_halt    = is_halt_r;
  assign stall_cnt  = stall_cnt_r;
  assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: default instance plus a CNT_W=4 instance
// sharing the same stimulus for the counter saturation case.
module tb_pipe_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] id_src1_adr, id_src2_adr, ex_dst_adr;
  logic       id_src1_use, id_src2_use, halt_id, ex_load, ex_regwrite;
  logic       branch_taken, mem_busy, resume;

  logic        en_pc, is_halt;
  logic [3:0]  en_pipe, flush_pipe;
  logic [4:0]  valid;
  logic [15:0] stall_cnt, flush_cnt;

  logic        en_pc4, is_halt4;
  logic [3:0]  en_pipe4, flush_pipe4;
  logic [4:0]  valid4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .id_src1_adr(id_src1_adr), .id_src2_adr(id_src2_adr),
    .id_src1_use(id_src1_use), .id_src2_use(id_src2_use),
    .halt_id(halt_id), .ex_load(ex_load), .ex_regwrite(ex_regwrite),
    .ex_dst_adr(ex_dst_adr), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .resume(resume),
    .en_pc(en_pc), .en_pipe(en_pipe), .flush_pipe(flush_pipe),
    .valid(valid), .is_halt(is_halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .id_src1_adr(id_src1_adr), .id_src2_adr(id_src2_adr),
    .id_src1_use(id_src1_use), .id_src2_use(id_src2_use),
    .halt_id(halt_id), .ex_load(ex_load), .ex_regwrite(ex_regwrite),
    .ex_dst_adr(ex_dst_adr), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .resume(resume),
    .en_pc(en_pc4), .en_pipe(en_pipe4), .flush_pipe(flush_pipe4),
    .valid(valid4), .is_halt(is_halt4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp_ctl(input string tag, input logic pc, input logic [3:0] en, input logic [3:0] fl);
    push({tag, " en_pc"}, 32'(pc));
    push({tag, " en_pipe"}, 32'(en));
    push({tag, " flush_pipe"}, 32'(fl));
  endtask

  task automatic chk_ctl();
    pop_chk(32'(en_pc));
    pop_chk(32'(en_pipe));
    pop_chk(32'(flush_pipe));
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_src1_adr = 3'd0; id_src2_adr = 3'd0; ex_dst_adr = 3'd0;
    id_src1_use = 1'b0; id_src2_use = 1'b0; halt_id = 1'b0;
    ex_load = 1'b0; ex_regwrite = 1'b0; branch_taken = 1'b0;
    mem_busy = 1'b0; resume = 1'b0;
  endtask

  task automatic set_lu(input logic [2:0] s1, input logic u1, input logic [2:0] s2, input logic u2);
    ex_load = 1'b1; ex_regwrite = 1'b1; ex_dst_adr = 3'd3;
    id_src1_adr = s1; id_src1_use = u1;
    id_src2_adr = s2; id_src2_use = u2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cyc();
      clear_in();
    end
  endtask

  initial begin
    clear_in();
    reset = 1'b0;
    #2;
    exp_ctl("reset", 1'b0, 4'b0000, 4'b1111);
    push("reset valid", 32'h0); push("reset is_halt", 32'h0);
    push("reset stall_cnt", 32'h0); push("reset flush_cnt", 32'h0);
    #1;
    chk_ctl(); pop_chk(32'(valid)); pop_chk(32'(is_halt));
    pop_chk(32'(stall_cnt)); pop_chk(32'(flush_cnt));

    // Release reset and watch the valid bits fill from fetch.
    next_cyc();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cyc();
      exp_ctl("fill", 1'b1, 4'b1111, 4'b0000);
      push("fill valid", (32'd1 << (i + 1)) - 32'd1);
      #3;
      chk_ctl(); pop_chk(32'(valid));
    end

    // Load-use on source 2, then the same inputs one cycle later with EX bubbled.
    next_cyc(); set_lu(3'd0, 1'b0, 3'd3, 1'b1);
    exp_ctl("lu", 1'b0, 4'b1110, 4'b0010);
    push("lu valid", 32'h1f); push("lu stall_cnt", 32'd0);
    #3; chk_ctl(); pop_chk(32'(valid)); pop_chk(32'(stall_cnt));
    next_cyc();
    exp_ctl("lu_once", 1'b1, 4'b1111, 4'b0000);
    push("lu_once valid", 32'h1b); push("lu_once stall_cnt", 32'd1);
    #3; chk_ctl(); pop_chk(32'(valid)); pop_chk(32'(stall_cnt));
    next_cyc(); set_lu(3'd3, 1'b0, 3'd5, 1'b1);
    exp_ctl("lu_unused_src", 1'b1, 4'b1111, 4'b0000);
    push("lu_unused_src valid", 32'h17);
    #3; chk_ctl(); pop_chk(32'(valid));
    next_cyc(); set_lu(3'd3, 1'b1, 3'd5, 1'b0);
    exp_ctl("lu_src1", 1'b0, 4'b1110, 4'b0010);
    #3; chk_ctl();
    idle(4);

    // Taken branch beats a simultaneous load-use.
    next_cyc(); set_lu(3'd0, 1'b0, 3'd3, 1'b1); branch_taken = 1'b1;
    exp_ctl("branch", 1'b1, 4'b1111, 4'b0011);
    push("branch flush_cnt", 32'd0);
    #3; chk_ctl(); pop_chk(32'(flush_cnt));
    next_cyc(); clear_in();
    push("branch_after valid", 32'h19); push("branch_after flush_cnt", 32'd1);
    push("branch_after stall_cnt", 32'd2);
    #3; pop_chk(32'(valid)); pop_chk(32'(flush_cnt)); pop_chk(32'(stall_cnt));
    idle(4);

    // Three cycles of memory wait.
    for (int i = 0; i < 3; i++) begin
      next_cyc(); mem_busy = 1'b1;
      exp_ctl("mem_busy", 1'b0, 4'b1000, 4'b1000);
      push("mem_busy valid", (i == 0) ? 32'h1f : 32'h0f);
      push("mem_busy stall_cnt", 32'd2 + 32'(i));
      #3; chk_ctl(); pop_chk(32'(valid)); pop_chk(32'(stall_cnt));
    end
    next_cyc(); clear_in();
    push("mem_after valid", 32'h0f); push("mem_after stall_cnt", 32'd5);
    #3; pop_chk(32'(valid)); pop_chk(32'(stall_cnt));
    idle(4);

    // Branch held under mem_busy takes effect and counts once afterwards.
    next_cyc(); mem_busy = 1'b1; branch_taken = 1'b1;
    exp_ctl("busy_branch", 1'b0, 4'b1000, 4'b1000);
    #3; chk_ctl();
    next_cyc(); mem_busy = 1'b0;
    exp_ctl("busy_branch_release", 1'b1, 4'b1111, 4'b0011);
    push("busy_branch_release flush_cnt", 32'd1);
    #3; chk_ctl(); pop_chk(32'(flush_cnt));
    next_cyc(); clear_in();
    push("busy_branch_after flush_cnt", 32'd2); push("busy_branch_after stall_cnt", 32'd6);
    #3; pop_chk(32'(flush_cnt)); pop_chk(32'(stall_cnt));
    idle(4);

    // Halt with one mem_busy cycle two cycles in; stray resume during drain.
    next_cyc(); halt_id = 1'b1;
    exp_ctl("halt_accept", 1'b1, 4'b1111, 4'b0000); push("halt_accept is_halt", 32'h0);
    #3; chk_ctl(); pop_chk(32'(is_halt));
    next_cyc(); halt_id = 1'b0;
    exp_ctl("drain1", 1'b0, 4'b1111, 4'b0001); push("drain1 is_halt", 32'h0);
    #3; chk_ctl(); pop_chk(32'(is_halt));
    next_cyc(); mem_busy = 1'b1;
    exp_ctl("drain_busy", 1'b0, 4'b1000, 4'b1001); push("drain_busy is_halt", 32'h0);
    #3; chk_ctl(); pop_chk(32'(is_halt));
    next_cyc(); mem_busy = 1'b0; resume = 1'b1;
    exp_ctl("drain_resume_ignored", 1'b0, 4'b1111, 4'b0001); push("drain3 is_halt", 32'h0);
    #3; chk_ctl(); pop_chk(32'(is_halt));
    next_cyc(); resume = 1'b0;
    exp_ctl("drain_last", 1'b0, 4'b1111, 4'b0001); push("drain_last is_halt", 32'h0);
    #3; chk_ctl(); pop_chk(32'(is_halt));
    for (int i = 0; i < 4; i++) begin
      next_cyc(); resume = (i == 3) ? 1'b1 : 1'b0;
      exp_ctl("halted", 1'b0, 4'b0000, 4'b0000); push("halted is_halt", 32'h1);
      #3; chk_ctl(); pop_chk(32'(is_halt));
    end
    next_cyc(); resume = 1'b0;
    exp_ctl("resumed", 1'b1, 4'b1111, 4'b0000); push("resumed is_halt", 32'h0);
    push("resumed stall_cnt", 32'd6); push("resumed flush_cnt", 32'd2);
    #3; chk_ctl(); pop_chk(32'(is_halt)); pop_chk(32'(stall_cnt)); pop_chk(32'(flush_cnt));
    idle(4);

    // Halt in decode squashed by a taken branch.
    next_cyc(); halt_id = 1'b1; branch_taken = 1'b1;
    exp_ctl("halt_branch", 1'b1, 4'b1111, 4'b0011);
    #3; chk_ctl();
    for (int i = 0; i < 6; i++) begin
      next_cyc(); clear_in();
      exp_ctl("halt_branch_run", 1'b1, 4'b1111, 4'b0000); push("halt_branch is_halt", 32'h0);
      #3; chk_ctl(); pop_chk(32'(is_halt));
    end
    push("halt_branch flush_cnt", 32'd3);
    pop_chk(32'(flush_cnt));

    // Halt re-presents after a load-use stall, then reset lands mid-drain.
    next_cyc(); halt_id = 1'b1; set_lu(3'd0, 1'b0, 3'd3, 1'b1);
    exp_ctl("halt_lu", 1'b0, 4'b1110, 4'b0010);
    #3; chk_ctl();
    next_cyc();
    exp_ctl("halt_lu_retry", 1'b1, 4'b1111, 4'b0000);
    #3; chk_ctl();
    next_cyc(); clear_in();
    exp_ctl("halt_lu_drain", 1'b0, 4'b1111, 4'b0001); push("halt_lu_drain stall_cnt", 32'd7);
    #3; chk_ctl(); pop_chk(32'(stall_cnt));
    next_cyc(); reset = 1'b0;
    exp_ctl("reset_drain", 1'b0, 4'b0000, 4'b1111);
    push("reset_drain is_halt", 32'h0); push("reset_drain valid", 32'h0);
    push("reset_drain stall_cnt", 32'd0); push("reset_drain flush_cnt", 32'd0);
    #3; chk_ctl(); pop_chk(32'(is_halt)); pop_chk(32'(valid));
    pop_chk(32'(stall_cnt)); pop_chk(32'(flush_cnt));
    next_cyc(); reset = 1'b1;
    exp_ctl("reset_release", 1'b1, 4'b1111, 4'b0000); push("reset_release valid", 32'h01);
    #3; chk_ctl(); pop_chk(32'(valid));
    idle(4);

    // Twenty load-use stalls: 16-bit counter reaches 20, 4-bit counter saturates.
    next_cyc(); set_lu(3'd0, 1'b0, 3'd3, 1'b1);
    repeat (39) next_cyc();
    next_cyc(); clear_in();
    push("sat stall_cnt", 32'd20); push("sat stall_cnt4", 32'd15);
    push("sat valid", 32'h17); push("sat valid4", 32'h17);
    push("sat en_pc4", 32'h1); push("sat en_pipe4", 32'hf); push("sat flush_pipe4", 32'h0);
    push("sat is_halt4", 32'h0); push("sat flush_cnt4", 32'h0);
    #3;
    pop_chk(32'(stall_cnt)); pop_chk(32'(stall_cnt4));
    pop_chk(32'(valid)); pop_chk(32'(valid4));
    pop_chk(32'(en_pc4)); pop_chk(32'(en_pipe4)); pop_chk(32'(flush_pipe4));
    pop_chk(32'(is_halt4)); pop_chk(32'(flush_cnt4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order core. It replaces the hand-wired per-register enable and flush signals with one block that does four things:

- detects load-use hazards, taken-branch squashes and main-memory wait stalls;
- sequences halt drain and resume;
- tracks a valid bit per stage;
- counts stall and flush events.

It drives the PC enable and every inter-stage register's enable and flush, for any stage count.

## Interface

Parameters:
- STAGES, 5, number of pipeline stages; 0 = fetch, STAGES-1 = writeback; minimum 4
- EX_STAGE, 2, index of the stage that resolves branches and holds loads
- MEM_STAGE, 3, index of the main-memory stage; EX_STAGE < MEM_STAGE < STAGES-1
- ADR_W, 3, register-address width
- CNT_W, 16, width of the event counters

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_src1_adr, id_src2_adr  in  ADR_W  source registers of the instruction in decode (stage 1)
- id_src1_use, id_src2_use  in  1  the decode instruction reads that source
- halt_id  in  1  the decode instruction is a halt
- ex_load  in  1  the EX instruction reads main memory
- ex_regwrite  in  1  the EX instruction writes a register
- ex_dst_adr  in  ADR_W  destination of the EX instruction
- branch_taken  in  1  the EX instruction redirects the PC; combinational from EX state
- mem_busy  in  1  main memory not ready this cycle
- resume  in  1  leave HALTED
- en_pc  out  1  PC register update enable
- en_pipe  out  STAGES-1  enable of register k, which sits between stage k and stage k+1
- flush_pipe  out  STAGES-1  synchronous clear (bubble) of register k; overrides en_pipe[k]
- valid  out  STAGES  stage k holds a live instruction
- is_halt  out  1  core halted
- stall_cnt  out  CNT_W  cycles with en_pc=0 while in RUN
- flush_cnt  out  CNT_W  taken-branch squash events

## Operation

- States: RUN, DRAIN, HALTED. Reset puts the block in RUN.
- valid[0] = 1 in RUN and 0 otherwise. valid[k+1] is registered:
  - 0 on flush_pipe[k];
  - valid[k] on en_pipe[k];
  - otherwise held.
- Events are qualified by valid: a branch only with valid[EX_STAGE], load-use only with valid[EX_STAGE] and valid[1], a halt only with valid[1].
- Priority in RUN is mem_busy > branch > load-use > halt. Default: everything enabled, no flush.
  - **mem_busy:** en_pc and registers 0..MEM_STAGE-1 held; register MEM_STAGE flushed; younger registers enabled.
  - **branch:** en_pc=1; registers 0..EX_STAGE-1 flushed; flush_cnt increments.
  - **load-use:** ex_load and ex_regwrite set, and ex_dst_adr equals a used source. en_pc=0, register 0 held, register 1 flushed, the rest enabled. Lasts exactly one cycle.
  - **halt:** no higher-priority event present. Normal advance this cycle; next state DRAIN; drain counter loaded with STAGES-2.
- A halt in decode during a branch or load-use cycle is not accepted:
  - branch: the halt is squashed;
  - load-use: the halt re-presents next cycle.
- **DRAIN:**
  - en_pc=0 and register 0 is flushed every cycle; all other registers advance.
  - mem_busy applies exactly as in RUN, and the drain counter holds during it.
  - Otherwise the counter decrements. At count 1 with no mem_busy, the next state is HALTED.
  - No branch or load-use action is taken; older instructions have already resolved.
- **HALTED:**
  - is_halt=1, en_pc=0, all en_pipe=0, no flushes.
  - resume moves to RUN next cycle; fetch continues from the held PC, which is the instruction after the halt.
- Counters saturate at all-ones. stall_cnt counts RUN cycles with en_pc=0 caused by mem_busy or load-use.

## Timing

- Asynchronous reset:
  - state RUN, valid=0, drain counter=0, is_halt=0, stall_cnt=0, flush_cnt=0;
  - while reset is low: en_pc=0, en_pipe all 0, flush_pipe all 1.
- Reset asserted mid-DRAIN or in HALTED returns immediately to the reset state.
- en_pc, en_pipe and flush_pipe are combinational from the inputs and registered state in the same cycle; there is no added latency.
- For the default parameters, halt_id accepted in cycle t gives DRAIN in t+1..t+3 and is_halt=1 from t+4, provided there is no mem_busy. Each mem_busy cycle during DRAIN delays is_halt by one cycle.
- A branch held under mem_busy re-asserts each cycle. It takes effect, and counts once, in the first cycle without mem_busy.
- resume is ignored outside HALTED. is_halt falls in the cycle after resume is sampled.

## Test plan

- **Load-use:** ex_load=1, ex_regwrite=1, ex_dst_adr=3, id_src2_adr=3, id_src2_use=1. Required: en_pc=0, flush_pipe=4'b0010, en_pipe[0]=0 for exactly 1 cycle; stall_cnt goes 0→1.
- **Taken branch:** branch_taken=1 with valid[2]=1 and a simultaneous load-use. Required: flush_pipe=4'b0011, en_pc=1; flush_cnt=1; stall_cnt unchanged.
- **Memory wait:** mem_busy=1 for 3 cycles. Required: en_pc=0 and en_pipe[2:0]=0 throughout; flush_pipe[3]=1; valid[4] goes 0 after the first cycle; stall_cnt +3.
- **Halt:** halt_id at t with one mem_busy cycle at t+2. Required: is_halt=1 from t+5; resume at t+8 gives en_pc=1 and is_halt=0 at t+9.
- **Halt during branch:** halt_id and branch_taken in the same cycle. Required: state stays RUN and is_halt never rises.
- **Reset and saturation:** reset pulled low during DRAIN. Required: is_halt=0 and flush_pipe all 1 immediately. Separately, with CNT_W=4, 20 load-use stalls leave stall_cnt=15.
